// File: rtl/sequence_evaluation_scheduler.sv
// sequence_evaluation_scheduler: steps through N stored test vectors, drives the evolved
// circuit, waits S settle cycles and accumulates saturating per-bit error counts.
module sequence_evaluation_scheduler #(
  parameter int SEQ_W    = 8,
  parameter int IDX_W    = 8,
  parameter int SETTLE_W = 16
) (
  input  logic                  iClock,
  input  logic                  iReset_n,
  input  logic                  iStart,
  input  logic [IDX_W-1:0]      iSequencesToProcess,
  input  logic [SETTLE_W-1:0]   iSettleCycles,
  input  logic                  iStall,
  output logic [IDX_W-1:0]      oSeqIndex,
  input  logic [SEQ_W-1:0]      iInputSequence,
  input  logic [SEQ_W-1:0]      iExpectedOutput,
  input  logic [SEQ_W-1:0]      iValidOutput,
  output logic [SEQ_W-1:0]      oCircuitInput,
  input  logic [SEQ_W-1:0]      iCircuitOutput,
  output logic [SEQ_W*32-1:0]   oErrorSums,
  output logic                  oBusy,
  output logic                  oDone,
  input  logic                  iDoneAck
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SETTLE, SAMPLE, DONE} state_t;
  state_t              r_state, w_next;
  logic [IDX_W-1:0]    r_last;
  logic [SETTLE_W-1:0] r_settle, r_cnt;
  logic [SEQ_W-1:0]    r_exp, r_val, w_err;
  logic [31:0]         r_sum [SEQ_W];
  logic                w_start;
  assign w_start = (r_state == IDLE) && iStart && !iStall;
  assign w_err   = (iCircuitOutput ^ r_exp) & r_val;
  for (genvar b = 0; b < SEQ_W; b++) begin : g_sums
    assign oErrorSums[32*b +: 32] = r_sum[b];
  end
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    oBusy  = !(r_state == IDLE || r_state == DONE);
    oDone  = r_state == DONE;
    if (!iStall) begin
      case (r_state)
        IDLE:    w_next = iStart ? FETCH : IDLE;
        FETCH:   w_next = LOAD;
        LOAD:    w_next = SETTLE;
        SETTLE:  w_next = (r_cnt == SETTLE_W'(1)) ? SAMPLE : SETTLE;
        SAMPLE:  w_next = (oSeqIndex == r_last) ? DONE : FETCH;
        DONE:    w_next = iDoneAck ? IDLE : DONE;
        default: w_next = IDLE;
      endcase
    end
  end
  // N-1 wraps naturally, so an encoded 0 (256 sequences) ends at index 255.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_last        <= '0;
      r_settle      <= '0;
      r_cnt         <= '0;
      r_exp         <= '0;
      r_val         <= '0;
      oSeqIndex     <= '0;
      oCircuitInput <= '0;
      for (int i = 0; i < SEQ_W; i++) r_sum[i] <= '0;
    end else if (!iStall) begin
      if (w_start) begin
        r_last    <= iSequencesToProcess - 1'b1;
        r_settle  <= (iSettleCycles == '0) ? SETTLE_W'(1) : iSettleCycles;
        oSeqIndex <= '0;
        for (int i = 0; i < SEQ_W; i++) r_sum[i] <= '0;
      end
      if (r_state == LOAD) begin
        oCircuitInput <= iInputSequence;
        r_exp         <= iExpectedOutput;
        r_val         <= iValidOutput;
        r_cnt         <= r_settle;
      end
      if (r_state == SETTLE) r_cnt <= r_cnt - 1'b1;
      if (r_state == SAMPLE) begin
        for (int i = 0; i < SEQ_W; i++)
          if (w_err[i] && r_sum[i] != '1) r_sum[i] <= r_sum[i] + 32'd1;
        if (oSeqIndex != r_last) oSeqIndex <= oSeqIndex + 1'b1;
      end
    end
  end
endmodule
